// File: rtl/sipo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sipo_pkg: shared state type and constants for sipo_deserializer  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

`ifdef SIPO_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PENDING = 1'b1
    } state_e;

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_bit_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sipo_bit_counter: frame bit counter, wraps on the last bit       |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module sipo_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [CNT_W-1:0] frame_len,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign last  = (count_q == (frame_len - CNT_W'(1)));
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = last ? '0 : (count_q + CNT_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sipo_deserializer: serial-in/parallel-out with a one-word output |
// | slot; optional even parity via SIPO_PARITY_EN.                   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             p_err
);

    localparam int FRAME = frame_len(WIDTH);
    localparam int CNT_W = $clog2(FRAME + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   p_out_q, p_out_d;
    logic               p_valid_q, p_valid_d;
    logic               p_err_q, p_err_d;
    logic               pend_err_q, pend_err_d;

    logic               w_accept;
    logic               w_last;
    logic [CNT_W-1:0]   w_count;
    logic               w_data_phase;
    logic               w_shift_en;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_err_new;

    assign s_ready  = rst & (state_q == COLLECT);
    assign w_accept = s_valid & s_ready;

    sipo_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_accept),
        .frame_len (CNT_W'(FRAME)),
        .count     (w_count),
        .last      (w_last)
    );

    // The parity bit (count == WIDTH) is consumed but never shifted into the word.
    assign w_data_phase = (w_count < CNT_W'(WIDTH));
    assign w_shift_en   = w_accept & w_data_phase;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {shift_q[WIDTH-2:0], s_in};
        end else begin : g_lsb_first
            assign w_shifted = {s_in, shift_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SIPO_PARITY_EN
    assign w_err_new = (^shift_q) ^ s_in;
`else
    assign w_err_new = 1'b0;
`endif

    always_comb begin
        shift_d = shift_q;
        if (w_shift_en) begin
            shift_d = w_shifted;
        end
    end

    always_comb begin
        state_d    = state_q;
        p_out_d    = p_out_q;
        p_valid_d  = p_valid_q;
        p_err_d    = p_err_q;
        pend_err_d = pend_err_q;
        case (state_q)
            COLLECT: begin
                if (w_accept && w_last) begin
                    if (!p_valid_q || p_ready) begin
                        p_out_d   = shift_d;
                        p_err_d   = w_err_new;
                        p_valid_d = 1'b1;
                    end else begin
                        pend_err_d = w_err_new;
                        state_d    = PENDING;
                    end
                end else if (p_valid_q && p_ready) begin
                    p_valid_d = 1'b0;
                end
            end
            PENDING: begin
                // p_valid is always set here, so p_ready alone frees the slot.
                if (p_ready) begin
                    p_out_d   = shift_q;
                    p_err_d   = pend_err_q;
                    p_valid_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= COLLECT;
            shift_q    <= '0;
            p_out_q    <= '0;
            p_valid_q  <= 1'b0;
            p_err_q    <= 1'b0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            p_out_q    <= p_out_d;
            p_valid_q  <= p_valid_d;
            p_err_q    <= p_err_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign p_err   = p_err_q;

endmodule
`default_nettype wire
